// File: rtl/perf_counter_bank_if.sv
// Bus bundle for perf_counter_bank: event strobes, control and the registered read port.
// The master side drives events/control; the slave side is the counter bank.
interface perf_counter_bank_if #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 32
);
    logic              enable;
    logic [NUM_CH-1:0] event_in;
    logic              halt;
    logic              clear;
    logic [3:0]        rd_sel;
    logic [CNT_W-1:0]  rd_data;
    logic [NUM_CH:0]   ovf;
    logic              frozen;

    modport master (
        output enable, event_in, halt, clear, rd_sel,
        input  rd_data, ovf, frozen
    );

    modport slave (
        input  enable, event_in, halt, clear, rd_sel,
        output rd_data, ovf, frozen
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Multi-channel event counter bank plus cycle counter; freezes on halt, zeroed by clear.
// Define PERF_CNT_SAT_EN to make counters saturate at all-ones instead of wrapping.
module perf_counter_bank #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    perf_counter_bank_if.slave  pif
);
    typedef enum logic {ST_RUN, ST_FROZEN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH+1];
    logic [CNT_W-1:0]  cnt_d [NUM_CH+1];
    logic [NUM_CH:0]   ovf_q, ovf_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic [NUM_CH:0]   inc_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            ovf_q     <= '0;
            rd_data_q <= '0;
            for (int i = 0; i <= NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            for (int i = 0; i <= NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ovf_d     = ovf_q;
        rd_data_d = '0;
        cnt_d     = cnt_q;
        // Top bit is the cycle counter, which ticks on every enabled edge.
        inc_v     = {1'b1, pif.event_in};

        if (pif.clear) begin
            state_d = ST_RUN;
            ovf_d   = '0;
            for (int i = 0; i <= NUM_CH; i++) begin
                cnt_d[i] = '0;
            end
        end else if (state_q == ST_RUN) begin
            if (pif.enable) begin
                for (int i = 0; i <= NUM_CH; i++) begin
                    if (inc_v[i]) begin
                        if (cnt_q[i] == {CNT_W{1'b1}}) begin
                            ovf_d[i] = 1'b1;
`ifdef PERF_CNT_SAT_EN
                            cnt_d[i] = cnt_q[i];
`else
                            cnt_d[i] = '0;
`endif
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end
            if (pif.halt) begin
                state_d = ST_FROZEN;
            end
        end

        // Read mux looks at next-state values so rd_data reflects the post-edge counters.
        for (int i = 0; i <= NUM_CH; i++) begin
            if (pif.rd_sel == 4'(i)) begin
                rd_data_d = cnt_d[i];
            end
        end
    end

    assign pif.rd_data = rd_data_q;
    assign pif.ovf     = ovf_q;
    assign pif.frozen  = (state_q == ST_FROZEN);
endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (NUM_CH=6, CNT_W=8) using a per-cycle scoreboard.
module tb_perf_counter_bank;
    localparam int NCH  = 6;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    typedef struct {
        logic [CW-1:0] rd;
        logic [NCH:0]  ovf;
        logic          frz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    int          mdl_cnt [0:NCH];
    logic [NCH:0] mdl_ovf;
    logic        mdl_frz;
    exp_t        exp_q[$];

    perf_counter_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .pif (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies the currently driven inputs for one edge, predicting the result first.
    task automatic step();
        exp_t         e;
        logic [NCH:0] incv;
        if (rst) begin
            for (int i = 0; i <= NCH; i++) mdl_cnt[i] = 0;
            mdl_ovf = '0;
            mdl_frz = 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i <= NCH; i++) mdl_cnt[i] = 0;
            mdl_ovf = '0;
            mdl_frz = 1'b0;
        end else if (!mdl_frz) begin
            if (bus.enable) begin
                incv = {1'b1, bus.event_in};
                for (int i = 0; i <= NCH; i++) begin
                    if (incv[i]) begin
                        if (mdl_cnt[i] == MAXV) begin
                            mdl_ovf[i] = 1'b1;
`ifdef PERF_CNT_SAT_EN
                            mdl_cnt[i] = MAXV;
`else
                            mdl_cnt[i] = 0;
`endif
                        end else begin
                            mdl_cnt[i] = mdl_cnt[i] + 1;
                        end
                    end
                end
            end
            if (bus.halt) mdl_frz = 1'b1;
        end
        e.rd = '0;
        for (int i = 0; i <= NCH; i++) begin
            if (int'(bus.rd_sel) == i) e.rd = CW'(mdl_cnt[i]);
        end
        e.ovf = mdl_ovf;
        e.frz = mdl_frz;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("rd_data", 64'(bus.rd_data), 64'(e.rd));
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
        chk("frozen", 64'(bus.frozen), 64'(e.frz));
    endtask

    task automatic drive(input logic en, input logic [NCH-1:0] ev, input logic h,
                         input logic c, input logic [3:0] sel);
        bus.enable   = en;
        bus.event_in = ev;
        bus.halt     = h;
        bus.clear    = c;
        bus.rd_sel   = sel;
        step();
    endtask

    task automatic rd(input logic [3:0] sel);
        drive(1'b0, '0, 1'b0, 1'b0, sel);
    endtask

    initial begin
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.event_in = '0;
        bus.halt     = 1'b0;
        bus.clear    = 1'b0;
        bus.rd_sel   = '0;
        mdl_ovf      = '0;
        mdl_frz      = 1'b0;
        for (int i = 0; i <= NCH; i++) mdl_cnt[i] = 0;

        step();
        step();
        chk("rst_rd", 64'(bus.rd_data), 64'd0);
        chk("rst_frozen", 64'(bus.frozen), 64'd0);
        rst = 1'b0;

        // Basic counting
        for (int k = 0; k < 10; k++) drive(1'b1, {3'b000, 1'b0, (k % 2 == 0), 1'b0, 1'b1}, 1'b0, 1'b0, 4'd0);
        rd(4'd0); chk("basic_ch0", 64'(bus.rd_data), 64'd10);
        rd(4'd2); chk("basic_ch2", 64'(bus.rd_data), 64'd5);
        rd(4'd6); chk("basic_cyc", 64'(bus.rd_data), 64'd10);
        drive(1'b1, '0, 1'b0, 1'b0, 4'd6);
        drive(1'b1, '0, 1'b0, 1'b0, 4'd6);
        chk("idle_cyc", 64'(bus.rd_data), 64'd12);

        // Enable gating
        for (int k = 0; k < 4; k++) drive(1'b0, '1, 1'b0, 1'b0, 4'(k));
        rd(4'd6); chk("gate_cyc", 64'(bus.rd_data), 64'd12);
        rd(4'd0); chk("gate_ch0", 64'(bus.rd_data), 64'd10);

        // Halt freeze
        drive(1'b0, '0, 1'b0, 1'b1, 4'd0);
        for (int k = 0; k < 7; k++) drive(1'b1, 6'b000010, 1'b0, 1'b0, 4'd1);
        drive(1'b1, 6'b000010, 1'b1, 1'b0, 4'd1);
        chk("halt_frozen", 64'(bus.frozen), 64'd1);
        chk("halt_ch1", 64'(bus.rd_data), 64'd8);
        for (int k = 0; k < 20; k++) drive(1'b1, '1, (k == 5), 1'b0, (k % 2 == 0) ? 4'd1 : 4'd6);
        rd(4'd1); chk("frz_ch1", 64'(bus.rd_data), 64'd8);
        rd(4'd6); chk("frz_cyc", 64'(bus.rd_data), 64'd8);
        chk("frz_still", 64'(bus.frozen), 64'd1);

        // Clear beats halt
        drive(1'b1, '1, 1'b1, 1'b1, 4'd6);
        chk("clr_frozen", 64'(bus.frozen), 64'd0);
        chk("clr_ovf", 64'(bus.ovf), 64'd0);
        for (int k = 0; k <= NCH; k++) begin
            rd(4'(k));
            chk("clr_read", 64'(bus.rd_data), 64'd0);
        end

        // Wrap / saturate on channel 4
        for (int k = 0; k < 257; k++) drive(1'b1, 6'b010000, 1'b0, 1'b0, 4'd4);
        rd(4'd4);
`ifdef PERF_CNT_SAT_EN
        chk("ovf_ch4", 64'(bus.rd_data), 64'd255);
`else
        chk("ovf_ch4", 64'(bus.rd_data), 64'd1);
`endif
        chk("ovf_ch_bits", 64'(bus.ovf[NCH-1:0]), 64'h10);
        chk("ovf_cyc_bit", 64'(bus.ovf[NCH]), 64'd1);

        // Read latency and out-of-range select
        drive(1'b0, '0, 1'b0, 1'b1, 4'd0);
        for (int k = 0; k < 5; k++) drive(1'b1, (k < 3) ? 6'b001001 : 6'b000001, 1'b0, 1'b0, 4'd0);
        rd(4'd0); chk("lat_ch0", 64'(bus.rd_data), 64'd5);
        rd(4'd3); chk("lat_ch3", 64'(bus.rd_data), 64'd3);
        rd(4'd15); chk("oor_read", 64'(bus.rd_data), 64'd0);

        // Reset mid-count while frozen
        drive(1'b1, '1, 1'b1, 1'b0, 4'd6);
        rst = 1'b1;
        drive(1'b1, '1, 1'b0, 1'b0, 4'd6);
        chk("rst_mid_rd", 64'(bus.rd_data), 64'd0);
        chk("rst_mid_frozen", 64'(bus.frozen), 64'd0);
        rst = 1'b0;

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            drive(1'($urandom_range(0, 3) != 0), NCH'($urandom), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
